// File: rtl/hasti_sram_slave.sv
// HASTI (AHB-Lite) SRAM slave with configurable data width, size, base
// address and wait states. Illegal accesses get a two-cycle ERROR response.
// A read whose data phase directly follows a write to the same word
// returns the merged new bytes.
module hasti_sram_slave #(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    ADDR_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE        = ADDR_WIDTH'(32'h2000_0000),
  parameter int                    SIZE        = 1024,
  parameter int                    WAIT_STATES = 0
) (
  input  logic                  hclk,
  input  logic                  hresetn,
  input  logic                  hsel,
  input  logic [ADDR_WIDTH-1:0] haddr,
  input  logic                  hwrite,
  input  logic [2:0]            hsize,
  input  logic [2:0]            hburst,
  input  logic [1:0]            htrans,
  input  logic [DATA_WIDTH-1:0] hwdata,
  input  logic                  hready,
  output logic [DATA_WIDTH-1:0] hrdata,
  output logic                  hreadyout,
  output logic                  hresp
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int LB    = $clog2(NB);
  localparam int DEPTH = SIZE / NB;
  localparam int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] SIZE_X   = (ADDR_WIDTH+1)'(SIZE);
  localparam logic [ADDR_WIDTH:0] BASE_X   = {1'b0, BASE};
  localparam logic [2:0]          MAX_SIZE = 3'(LB);
  localparam logic [1:0]          WS_INIT  = 2'(WAIT_STATES);

  typedef enum logic [1:0] {
    ST_READY = 2'd0,
    ST_WAIT  = 2'd1,
    ST_ERR1  = 2'd2,
    ST_ERR2  = 2'd3
  } state_t;

  state_t                state_r, state_nxt_s;
  logic [1:0]            cnt_r, cnt_nxt_s;
  logic                  hreadyout_r, hreadyout_nxt_s;
  logic                  hresp_r, hresp_nxt_s;
  logic [DATA_WIDTH-1:0] hrdata_r;

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];

  logic [ADDR_WIDTH:0]   off_s;
  logic [LB-1:0]         lane_s;
  logic [IW-1:0]         idx_s;
  logic [2:0]            align_mask_s;
  logic [7:0]            bytes_s;
  logic [NB-1:0]         strb_s;
  logic                  legal_s;
  logic                  accept_s;

  logic                  ph_valid_r;
  logic                  ph_write_r;
  logic [IW-1:0]         ph_idx_r;
  logic [NB-1:0]         ph_strb_r;
  logic                  complete_s;
  logic                  commit_s;

  logic                  rd_load_s;
  logic [IW-1:0]         rd_idx_s;
  logic [DATA_WIDTH-1:0] merged_s;
  logic [DATA_WIDTH-1:0] rd_word_s;

  // burst type is informational only
  logic unused_ok_s;
  assign unused_ok_s = &{1'b0, hburst};

  // Address-phase decode: offset (one extra bit so addresses below BASE stay out of range), legality, lane strobes
  always_comb begin
    off_s  = {1'b0, haddr} - BASE_X;
    lane_s = off_s[LB-1:0];
    idx_s  = off_s[LB+IW-1:LB];
    case (hsize)
      3'd0:    begin align_mask_s = 3'b000; bytes_s = 8'h01; end
      3'd1:    begin align_mask_s = 3'b001; bytes_s = 8'h03; end
      3'd2:    begin align_mask_s = 3'b011; bytes_s = 8'h0F; end
      3'd3:    begin align_mask_s = 3'b111; bytes_s = 8'hFF; end
      default: begin align_mask_s = 3'b111; bytes_s = 8'hFF; end
    endcase
    strb_s   = NB'(bytes_s << lane_s);
    legal_s  = (off_s < SIZE_X) && (hsize <= MAX_SIZE) &&
               ((off_s[2:0] & align_mask_s) == 3'b000);
    accept_s = hsel & hready & htrans[1] & hreadyout_r;
  end

  // Next-state logic for the response sequencer
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      ST_READY, ST_ERR2: begin
        if (accept_s) begin
          if (!legal_s) begin
            state_nxt_s = ST_ERR1;
            cnt_nxt_s   = 2'd0;
          end else if (WAIT_STATES > 0) begin
            state_nxt_s = ST_WAIT;
            cnt_nxt_s   = WS_INIT;
          end else begin
            state_nxt_s = ST_READY;
            cnt_nxt_s   = 2'd0;
          end
        end else if (state_r == ST_ERR2) begin
          state_nxt_s = ST_READY;
          cnt_nxt_s   = 2'd0;
        end else begin
          state_nxt_s = state_r;
          cnt_nxt_s   = cnt_r;
        end
      end
      ST_WAIT: begin
        if (cnt_r == 2'd1) begin
          state_nxt_s = ST_READY;
          cnt_nxt_s   = 2'd0;
        end else begin
          state_nxt_s = ST_WAIT;
          cnt_nxt_s   = cnt_r - 2'd1;
        end
      end
      ST_ERR1: begin
        state_nxt_s = ST_ERR2;
        cnt_nxt_s   = 2'd0;
      end
      default: begin
        state_nxt_s = ST_READY;
        cnt_nxt_s   = 2'd0;
      end
    endcase
  end

  // Output decode of the next state so hreadyout/hresp come straight from flops
  always_comb begin
    case (state_nxt_s)
      ST_READY: begin hreadyout_nxt_s = 1'b1; hresp_nxt_s = 1'b0; end
      ST_WAIT:  begin hreadyout_nxt_s = 1'b0; hresp_nxt_s = 1'b0; end
      ST_ERR1:  begin hreadyout_nxt_s = 1'b0; hresp_nxt_s = 1'b1; end
      ST_ERR2:  begin hreadyout_nxt_s = 1'b1; hresp_nxt_s = 1'b1; end
      default:  begin hreadyout_nxt_s = 1'b1; hresp_nxt_s = 1'b0; end
    endcase
  end

  // State and response registers
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_r     <= ST_READY;
      cnt_r       <= 2'd0;
      hreadyout_r <= 1'b1;
      hresp_r     <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      cnt_r       <= cnt_nxt_s;
      hreadyout_r <= hreadyout_nxt_s;
      hresp_r     <= hresp_nxt_s;
    end
  end

  assign complete_s = ph_valid_r & hreadyout_r & hready;
  assign commit_s   = complete_s & ph_write_r;

  // Address-phase capture for the legal transfer now in its data phase
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      ph_valid_r <= 1'b0;
      ph_write_r <= 1'b0;
      ph_idx_r   <= '0;
      ph_strb_r  <= '0;
    end else if (accept_s) begin
      ph_valid_r <= legal_s;
      ph_write_r <= hwrite;
      ph_idx_r   <= idx_s;
      ph_strb_r  <= strb_s;
    end else if (complete_s) begin
      ph_valid_r <= 1'b0;
    end
  end

  // Read-data source: with no wait states the word is fetched at accept and
  // may coincide with a write committing at the same edge, so merge it in
  always_comb begin
    if (WAIT_STATES == 0) begin
      rd_load_s = accept_s & legal_s & ~hwrite;
      rd_idx_s  = idx_s;
    end else begin
      rd_load_s = (state_r == ST_WAIT) && (cnt_r == 2'd1) && ph_valid_r && !ph_write_r;
      rd_idx_s  = ph_idx_r;
    end
    for (int b = 0; b < NB; b++) begin
      merged_s[8*b +: 8] = ph_strb_r[b] ? hwdata[8*b +: 8] : mem_r[ph_idx_r][8*b +: 8];
    end
    if (commit_s && (ph_idx_r == rd_idx_s)) begin
      rd_word_s = merged_s;
    end else begin
      rd_word_s = mem_r[rd_idx_s];
    end
  end

  // Read-data register; holds between OKAY read data phases
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      hrdata_r <= '0;
    end else if (rd_load_s) begin
      hrdata_r <= rd_word_s;
    end else begin
      hrdata_r <= hrdata_r;
    end
  end

  // Memory array (contents survive reset); write lands at the end of the data phase
  always_ff @(posedge hclk) begin
    if (commit_s) begin
      mem_r[ph_idx_r] <= merged_s;
    end
  end

  assign hrdata    = hrdata_r;
  assign hreadyout = hreadyout_r;
  assign hresp     = hresp_r;

endmodule

// File: tb/tb_hasti_sram_slave.sv
// Bench for hasti_sram_slave: a 32-bit zero-wait instance and a 64-bit
// two-wait-state instance share one bus; a byte-addressed reference memory
// predicts read data, response and latency for every transfer.
module tb_hasti_sram_slave;

  localparam logic [31:0] BASE = 32'h2000_0000;

  typedef struct {
    logic [1:0]  trans;
    logic        wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [63:0] wdata;
  } beat_t;

  logic        hclk;
  logic        hresetn;
  logic        hsel;
  logic [31:0] haddr;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [1:0]  htrans;
  logic [63:0] hwdata;
  logic        hready;
  logic        hsel0, hsel1;
  logic [31:0] hrdata0;
  logic [63:0] hrdata1;
  logic        hro0, hro1, hresp0, hresp1;
  bit          which;

  int          errors = 0;
  int          checks = 0;
  beat_t       q[$];
  logic [7:0]  mm [0:1][0:1023];
  logic [63:0] last_rdata;

  assign hsel0  = hsel & ~which;
  assign hsel1  = hsel & which;
  assign hready = which ? hro1 : hro0;

  hasti_sram_slave #(.DATA_WIDTH(32), .WAIT_STATES(0)) u_dut0 (
    .hclk(hclk), .hresetn(hresetn), .hsel(hsel0), .haddr(haddr), .hwrite(hwrite),
    .hsize(hsize), .hburst(hburst), .htrans(htrans), .hwdata(hwdata[31:0]),
    .hready(hready), .hrdata(hrdata0), .hreadyout(hro0), .hresp(hresp0));

  hasti_sram_slave #(.DATA_WIDTH(64), .WAIT_STATES(2)) u_dut1 (
    .hclk(hclk), .hresetn(hresetn), .hsel(hsel1), .haddr(haddr), .hwrite(hwrite),
    .hsize(hsize), .hburst(hburst), .htrans(htrans), .hwdata(hwdata),
    .hready(hready), .hrdata(hrdata1), .hreadyout(hro1), .hresp(hresp1));

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  function automatic logic sel_ro();
    return which ? hro1 : hro0;
  endfunction

  function automatic logic sel_resp();
    return which ? hresp1 : hresp0;
  endfunction

  function automatic logic [63:0] sel_rdata();
    return which ? hrdata1 : {32'h0, hrdata0};
  endfunction

  function automatic int nb();
    return which ? 8 : 4;
  endfunction

  function automatic int ws();
    return which ? 2 : 0;
  endfunction

  function automatic bit legal(input logic [31:0] a, input logic [2:0] s);
    longint off;
    off = longint'(a) - longint'(BASE);
    if (off < 0 || off >= 1024) return 1'b0;
    if (int'(s) > (which ? 3 : 2)) return 1'b0;
    if ((off % (longint'(1) << s)) != 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [63:0] model_read(input logic [31:0] a);
    int off;
    int wbase;
    logic [63:0] w;
    off   = int'(a - BASE);
    wbase = off - (off % nb());
    w     = 64'h0;
    for (int b = 0; b < nb(); b++) w[8*b +: 8] = mm[which][wbase + b];
    return w;
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [2:0] s, input logic [63:0] d);
    int off;
    int lane;
    off = int'(a - BASE);
    for (int k = 0; k < (1 << s); k++) begin
      lane = (off + k) % nb();
      mm[which][off + k] = d[8*lane +: 8];
    end
  endtask

  task automatic push(input logic [1:0] t, input logic w, input logic [31:0] a,
                      input logic [2:0] s, input logic [63:0] d);
    beat_t b;
    b.trans = t; b.wr = w; b.addr = a; b.size = s; b.wdata = d;
    q.push_back(b);
  endtask

  // Pipelined AHB master over the queued beats; every data phase is checked
  // for per-cycle response, latency and (for legal reads) data.
  task automatic run_seq(input string tag);
    int n, ap, dp, low, cyc, exp_low;
    bit lg, er;
    logic [63:0] exp_w;
    n = q.size(); ap = 0; dp = -1; low = 0; cyc = 0;
    while ((ap < n || dp >= 0) && cyc < n*10 + 20) begin
      @(negedge hclk);
      cyc++;
      if (ap < n) begin
        hsel = 1'b1; htrans = q[ap].trans; hwrite = q[ap].wr;
        haddr = q[ap].addr; hsize = q[ap].size;
      end else begin
        hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0;
      end
      if (dp >= 0) begin
        hwdata = q[dp].wdata;
        lg = q[dp].trans[1] && legal(q[dp].addr, q[dp].size);
        er = q[dp].trans[1] && !lg;
        exp_low = er ? 1 : (lg ? ws() : 0);
        if (!sel_ro()) begin
          low++;
          checks++;
          if (sel_resp() !== er) begin
            errors++;
            $display("FAIL %s resp_wait beat %0d: got %b want %b", tag, dp, sel_resp(), er);
          end
        end else begin
          checks++;
          if (low != exp_low) begin
            errors++;
            $display("FAIL %s latency beat %0d: got %0d low cycles want %0d", tag, dp, low, exp_low);
          end
          checks++;
          if (sel_resp() !== er) begin
            errors++;
            $display("FAIL %s resp beat %0d: got %b want %b", tag, dp, sel_resp(), er);
          end
          if (lg && !q[dp].wr) begin
            exp_w = model_read(q[dp].addr);
            last_rdata = sel_rdata();
            checks++;
            if (sel_rdata() !== exp_w) begin
              errors++;
              $display("FAIL %s rdata beat %0d addr %h: got %h want %h", tag, dp, q[dp].addr, sel_rdata(), exp_w);
            end
          end
          if (lg && q[dp].wr) model_write(q[dp].addr, q[dp].size, q[dp].wdata);
          dp = -1;
        end
      end
      if (sel_ro() && dp < 0 && ap < n) begin
        dp = ap; ap++; low = 0;
      end
    end
    if (ap < n || dp >= 0) begin
      checks++; errors++;
      $display("FAIL %s timeout: got %0d beats issued want %0d", tag, ap, n);
    end
    q.delete();
  endtask

  task automatic test_reset();
    #12;
    checks += 6;
    if (hro0 !== 1'b1)     begin errors++; $display("FAIL rst_in ro0: got %b want 1", hro0); end
    if (hresp0 !== 1'b0)   begin errors++; $display("FAIL rst_in resp0: got %b want 0", hresp0); end
    if (hrdata0 !== 32'h0) begin errors++; $display("FAIL rst_in rdata0: got %h want 0", hrdata0); end
    if (hro1 !== 1'b1)     begin errors++; $display("FAIL rst_in ro1: got %b want 1", hro1); end
    if (hresp1 !== 1'b0)   begin errors++; $display("FAIL rst_in resp1: got %b want 0", hresp1); end
    if (hrdata1 !== 64'h0) begin errors++; $display("FAIL rst_in rdata1: got %h want 0", hrdata1); end
    @(negedge hclk); hresetn = 1'b1;
    @(negedge hclk);
    checks += 4;
    if (hro0 !== 1'b1)   begin errors++; $display("FAIL rst_out ro0: got %b want 1", hro0); end
    if (hresp0 !== 1'b0) begin errors++; $display("FAIL rst_out resp0: got %b want 0", hresp0); end
    if (hro1 !== 1'b1)   begin errors++; $display("FAIL rst_out ro1: got %b want 1", hro1); end
    if (hresp1 !== 1'b0) begin errors++; $display("FAIL rst_out resp1: got %b want 0", hresp1); end
  endtask

  task automatic test_init();
    which = 1'b0;
    for (int i = 0; i < 256; i++) push(2'b10, 1'b1, BASE + 32'(4*i), 3'd2, {32'h0, $urandom});
    run_seq("init0");
    which = 1'b1;
    for (int i = 0; i < 128; i++) push(2'b10, 1'b1, BASE + 32'(8*i), 3'd3, {$urandom, $urandom});
    run_seq("init1");
  endtask

  task automatic test_word_rw();
    which = 1'b0;
    push(2'b10, 1'b1, 32'h2000_0004, 3'd2, 64'hDEADBEEF);
    push(2'b00, 1'b0, 32'h2000_0004, 3'd2, 64'h0);
    push(2'b10, 1'b0, 32'h2000_0004, 3'd2, 64'h0);
    run_seq("word_rw");
    checks++;
    if (last_rdata[31:0] !== 32'hDEADBEEF) begin
      errors++; $display("FAIL word_rw const: got %h want deadbeef", last_rdata[31:0]);
    end
  endtask

  task automatic test_byte_strobe();
    which = 1'b0;
    push(2'b10, 1'b1, 32'h2000_0008, 3'd2, 64'h11223344);
    push(2'b10, 1'b1, 32'h2000_000A, 3'd0, 64'h00AA0000);
    push(2'b10, 1'b0, 32'h2000_0008, 3'd2, 64'h0);
    run_seq("byte_strobe");
    checks++;
    if (last_rdata[31:0] !== 32'h11AA3344) begin
      errors++; $display("FAIL byte_strobe const: got %h want 11aa3344", last_rdata[31:0]);
    end
    which = 1'b1;
    push(2'b10, 1'b1, 32'h2000_0100, 3'd3, 64'h0123456789ABCDEF);
    push(2'b10, 1'b1, 32'h2000_0106, 3'd1, 64'h5A5A_0000_0000_0000);
    push(2'b10, 1'b0, 32'h2000_0100, 3'd3, 64'h0);
    run_seq("dword");
    checks++;
    if (last_rdata !== 64'h5A5A456789ABCDEF) begin
      errors++; $display("FAIL dword const: got %h want 5a5a456789abcdef", last_rdata);
    end
  endtask

  task automatic test_forwarding();
    which = 1'b0;
    push(2'b10, 1'b1, 32'h2000_0010, 3'd2, 64'h55);
    push(2'b10, 1'b0, 32'h2000_0010, 3'd2, 64'h0);
    run_seq("forward");
    checks++;
    if (last_rdata[31:0] !== 32'h00000055) begin
      errors++; $display("FAIL forward const: got %h want 00000055", last_rdata[31:0]);
    end
    push(2'b10, 1'b1, 32'h2000_0013, 3'd0, 64'h7700_0000);
    push(2'b11, 1'b0, 32'h2000_0010, 3'd2, 64'h0);
    run_seq("forward_byte");
    checks++;
    if (last_rdata[31:0] !== 32'h77000055) begin
      errors++; $display("FAIL forward_byte const: got %h want 77000055", last_rdata[31:0]);
    end
  endtask

  task automatic test_errors();
    which = 1'b0;
    push(2'b10, 1'b1, 32'h2000_0000, 3'd2, 64'hA5A50F0F);
    push(2'b10, 1'b0, 32'h2000_0400, 3'd2, 64'h0);
    push(2'b10, 1'b1, 32'h2000_0001, 3'd1, 64'hFFFFFFFF);
    push(2'b10, 1'b1, 32'h2000_0000, 3'd3, 64'hFFFFFFFF);
    push(2'b10, 1'b0, 32'h2000_0000, 3'd2, 64'h0);
    run_seq("err32");
    checks++;
    if (last_rdata[31:0] !== 32'hA5A50F0F) begin
      errors++; $display("FAIL err32 unchanged: got %h want a5a50f0f", last_rdata[31:0]);
    end
    which = 1'b1;
    push(2'b10, 1'b1, 32'h2000_03FF, 3'd0, 64'hC3C3_C3C3_C3C3_C3C3);
    push(2'b10, 1'b1, 32'h2000_0400, 3'd0, 64'hFFFF_FFFF_FFFF_FFFF);
    push(2'b10, 1'b1, 32'h1FFF_FFFF, 3'd0, 64'hFFFF_FFFF_FFFF_FFFF);
    push(2'b10, 1'b1, 32'h2000_03FA, 3'd2, 64'hFFFF_FFFF_FFFF_FFFF);
    push(2'b10, 1'b0, 32'h2000_03F8, 3'd3, 64'h0);
    run_seq("err64");
    checks++;
    if (last_rdata[63:56] !== 8'hC3) begin
      errors++; $display("FAIL err64 top_byte: got %h want c3", last_rdata[63:56]);
    end
  endtask

  task automatic test_wait_burst();
    which = 1'b1;
    hburst = 3'b011;
    push(2'b10, 1'b0, 32'h2000_0020, 3'd3, 64'h0);
    push(2'b11, 1'b0, 32'h2000_0028, 3'd3, 64'h0);
    push(2'b00, 1'b0, 32'h2000_0030, 3'd3, 64'h0);
    push(2'b11, 1'b0, 32'h2000_0030, 3'd3, 64'h0);
    push(2'b11, 1'b0, 32'h2000_0038, 3'd3, 64'h0);
    run_seq("burst");
    hburst = 3'b000;
  endtask

  task automatic test_back_to_back();
    int r, off;
    logic [2:0] s;
    logic [31:0] a;
    logic [1:0] t;
    for (int d = 0; d < 2; d++) begin
      which = (d == 1);
      for (int i = 0; i < 80; i++) begin
        r   = $urandom_range(0, 19);
        s   = 3'($urandom_range(0, 3));
        off = $urandom_range(0, 1023);
        off = off - (off % (1 << s));
        a   = BASE + 32'(off);
        t   = 2'b10;
        if (r == 0)       a = a | 32'h1;
        else if (r == 1)  a = 32'h2000_0400 + 32'($urandom_range(0, 15));
        else if (r == 2)  a = 32'h1FFF_FFF0 + 32'($urandom_range(0, 15));
        else if (r == 3)  t = 2'b00;
        else if (r == 4)  t = 2'b01;
        else if (r < 10)  t = 2'b11;
        else              t = 2'b10;
        push(t, 1'($urandom_range(0, 1)), a, s, {$urandom, $urandom});
      end
      run_seq(which ? "random64" : "random32");
    end
  endtask

  task automatic test_reset_mid();
    logic [63:0] aborted;
    aborted = 64'hCAFE_F00D_1234_5678;
    which = 1'b1;
    @(negedge hclk);
    hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = 32'h2000_0040; hsize = 3'd3;
    @(negedge hclk);
    hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; hwdata = aborted;
    checks++;
    if (hro1 !== 1'b0) begin errors++; $display("FAIL rst_mid wait: got ro %b want 0", hro1); end
    #2 hresetn = 1'b0;
    #1;
    checks += 3;
    if (hro1 !== 1'b1)     begin errors++; $display("FAIL rst_mid ro: got %b want 1", hro1); end
    if (hresp1 !== 1'b0)   begin errors++; $display("FAIL rst_mid resp: got %b want 0", hresp1); end
    if (hrdata1 !== 64'h0) begin errors++; $display("FAIL rst_mid rdata: got %h want 0", hrdata1); end
    @(negedge hclk);
    hresetn = 1'b1;
    push(2'b10, 1'b0, 32'h2000_0040, 3'd3, 64'h0);
    run_seq("rst_mid_read");
    checks++;
    if (last_rdata === aborted) begin
      errors++; $display("FAIL rst_mid aborted: got %h want old contents", last_rdata);
    end
  endtask

  initial begin
    hresetn = 1'b0; hsel = 1'b0; haddr = 32'h0; hwrite = 1'b0; hsize = 3'd0;
    hburst = 3'd0; htrans = 2'b00; hwdata = 64'h0; which = 1'b0; last_rdata = 64'h0;
    test_reset();
    test_init();
    test_word_rw();
    test_byte_strobe();
    test_forwarding();
    test_errors();
    test_wait_burst();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hasti_sram_slave.md
# hasti_sram_slave

Parametrised HASTI (AHB-Lite) SRAM slave that replaces the fixed 32-bit ROM/RAM slaves behind the system interconnect. It generalises data width (32 or 64 bits), memory size, base address and wait-state count. It adds byte/halfword/word/dword write strobing, a two-cycle ERROR response for illegal accesses, and read-after-write forwarding. It sits on one HASTI slave port of the vscale system bus.

## Interface
- DATA_WIDTH, 32, bus data width; 32 or 64
- ADDR_WIDTH, 32, bus address width
- BASE, 32'h20000000, byte base address; aligned to SIZE
- SIZE, 1024, memory size in bytes; power of two, ≥ DATA_WIDTH/8
- WAIT_STATES, 0, extra data-phase cycles per OKAY transfer; 0..3

Ports:
- hclk  in  1  bus clock, all state on rising edge
- hresetn  in  1  asynchronous active-low reset
- hsel  in  1  slave select (address phase)
- haddr  in  ADDR_WIDTH  byte address
- hwrite  in  1  1 = write
- hsize  in  3  hsize_t: BYTE/HALFWORD/WORD/DWORD
- hburst  in  3  hburst_t; informational only, not checked
- htrans  in  2  htrans_t
- hwdata  in  DATA_WIDTH  write data (data phase)
- hready  in  1  bus-wide ready; address phase sampled only when high
- hrdata  out  DATA_WIDTH  read data
- hreadyout  out  1  slave ready
- hresp  out  1  hresp_t: OKAY/ERROR

## Operation
- Accept: the address phase is accepted on a rising edge with hsel & hready & htrans ∈ {NONSEQ, SEQ}.
- No transfer: IDLE/BUSY, or hsel=0, produce a zero-wait OKAY data phase.
- Illegal access. Any of the following gives ERROR, with no memory write:
  - offset = haddr − BASE ≥ SIZE, or haddr < BASE
  - hsize > log2(DATA_WIDTH/8)
  - haddr not aligned to 2^hsize
- Lane/strobe: lane = offset[log2(DATA_WIDTH/8)−1:0]; 2^hsize bytes are enabled starting at lane. Word index = offset >> log2(DATA_WIDTH/8).
- Write: hwdata bytes in the enabled lanes are written at the edge that ends the data phase. The AHB lane placement is used; hwdata is not shifted.
- Read: hrdata carries the full aligned word at the word index. It is valid only while hreadyout=1 & hresp=OKAY; it holds its previous value otherwise.
- Forwarding: a read whose data phase immediately follows a write data phase to the same word returns the merged new bytes.
- Bursts: the slave uses haddr on every beat and generates no addresses.
- States:
  - READY: hreadyout=1, hresp=OKAY
  - WAIT(n): hreadyout=0, hresp=OKAY
  - ERR1: hreadyout=0, hresp=ERROR
  - ERR2: hreadyout=1, hresp=ERROR
- Transitions:
  - Accepted legal transfer → WAIT(WAIT_STATES) if WAIT_STATES>0, else stays READY.
  - WAIT(n) → WAIT(n−1); WAIT(1) → READY.
  - Accepted illegal transfer → ERR1 → ERR2. An accept in ERR2 (hready=1) is evaluated normally; otherwise ERR2 → READY.
- Stalls: while hreadyout=0, bus inputs are ignored. Address-phase signals are registered at accept.
- Bus stalls: if hready=0 because another slave stalls, no accept occurs and the state is unchanged.

## Timing
- Reset (async assert, sync-safe deassert): hreadyout=1, hresp=OKAY, hrdata=0, state READY, pending write/forwarding cleared. Memory contents are not reset.
- Reset asserted mid data phase: the write is discarded and outputs take reset values immediately.
- OKAY latency: the data phase lasts WAIT_STATES+1 cycles. hreadyout is low for the first WAIT_STATES cycles.
- ERROR: always exactly 2 data-phase cycles, independent of WAIT_STATES.
- Back-to-back pipelining: a new address phase may be accepted in the last data-phase cycle of the previous transfer.
- Boundary addresses:
  - haddr = BASE+SIZE−1 with BYTE is legal.
  - haddr = BASE+SIZE is ERROR.
  - Offset arithmetic is done in ADDR_WIDTH+1 bits so haddr < BASE does not wrap into range.

## Test plan
- Zero-wait word write/read (DATA_WIDTH=32, WAIT_STATES=0): write 32'hDEADBEEF to 0x20000004, then read the same address → hrdata=32'hDEADBEEF in the cycle after the read address phase, hresp=OKAY, hreadyout never low.
- Byte strobes: write word 32'h11223344 to 0x20000008, then byte 8'hAA (hwdata=32'h00AA0000) to 0x2000000A → read returns 32'h11AA3344. On DATA_WIDTH=64, a DWORD write/read round-trips 64'h0123456789ABCDEF.
- Forwarding: a write 32'h55 to 0x20000010 immediately followed by a NONSEQ read of 0x20000010 → read returns 32'h00000055.
- Errors, each giving hreadyout 0 then 1 with hresp=ERROR both cycles and memory unchanged:
  - read at 0x20000400 (SIZE=1024)
  - HALFWORD at 0x20000001
  - DWORD on a 32-bit bus
- Wait states (WAIT_STATES=2): an INCR4 read burst → each beat has hreadyout low 2 cycles then high with correct data. An IDLE inserted mid-burst gives a zero-wait OKAY.
- Reset: assert hresetn low during WAIT of a write → outputs immediately hreadyout=1, hresp=OKAY, hrdata=0; a later read of that address does not show the aborted data.
